// File: rtl/complex_to_mag_pkg.sv
// complex_to_mag_pkg: estimator mode encodings and width helpers
// shared by the magnitude pipeline and its peak tracker.
package complex_to_mag_pkg;

    typedef enum logic [1:0] {
        MODE_L1   = 2'd0,
        MODE_AMBM = 2'd1,
        MODE_LINF = 2'd2,
        MODE_SQ   = 2'd3
    } mode_e;

    // Result width of the linear estimators (modes 0-2).
    function automatic int lin_w(input int w);
        return w + 1;
    endfunction

    // Exact width of Re^2 + Im^2 for w-bit signed inputs.
    function automatic int sq_w(input int w);
        return 2 * w;
    endfunction

    // Low bits dropped when the linear result is wider than the output.
    function automatic int drop_w(input int lw, input int mw);
        return (mw < lw) ? lw - mw : 0;
    endfunction

endpackage

// File: rtl/complex_to_mag_pipe_if.sv
// complex_to_mag_pipe_if: valid/ready stream bundle (tdata, tlast).
// master drives valid/data/last, slave drives ready.
interface complex_to_mag_pipe_if #(
    parameter int DW = 48
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/c2m_peak_tracker.sv
// c2m_peak_tracker: per-frame strongest-bin search on the output stream.
// Ports: fire/last/mag from the output handshake; peak_valid/mag/idx out.
module c2m_peak_tracker #(
    parameter int MAG_WIDTH = 24,
    parameter int IDX_WIDTH = 10
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 fire,
    input  logic                 last,
    input  logic [MAG_WIDTH-1:0] mag,
    output logic                 peak_valid,
    output logic [MAG_WIDTH-1:0] peak_mag,
    output logic [IDX_WIDTH-1:0] peak_idx
);

    logic [IDX_WIDTH-1:0] bin;
    logic [MAG_WIDTH-1:0] run_mag;
    logic [IDX_WIDTH-1:0] run_idx;
    logic                 take;
    logic [MAG_WIDTH-1:0] best_mag;
    logic [IDX_WIDTH-1:0] best_idx;

    // Bin 0 always loads; strict compare keeps the earlier bin on ties.
    assign take     = (bin == '0) || (mag > run_mag);
    assign best_mag = take ? mag : run_mag;
    assign best_idx = take ? bin : run_idx;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            bin        <= '0;
            run_mag    <= '0;
            run_idx    <= '0;
            peak_valid <= 1'b0;
            peak_mag   <= '0;
            peak_idx   <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (fire) begin
                if (last) begin
                    peak_valid <= 1'b1;
                    peak_mag   <= best_mag;
                    peak_idx   <= best_idx;
                    bin        <= '0;
                    run_mag    <= '0;
                    run_idx    <= '0;
                end else begin
                    bin     <= bin + 1'b1;
                    run_mag <= best_mag;
                    run_idx <= best_idx;
                end
            end
        end
    end

endmodule

// File: rtl/complex_to_mag_pipe.sv
// complex_to_mag_pipe: 3-stage {Re,Im} -> magnitude pipeline with
// per-frame estimator select (cfg_mode), s_axis in, m_axis out, peak_* out.
module complex_to_mag_pipe
    import complex_to_mag_pkg::*;
#(
    parameter int RE_IM_WIDTH = 24,
    parameter int MAG_WIDTH   = 24,
    parameter int IDX_WIDTH   = 10,
    parameter int SQ_SHIFT    = 24
) (
    input  logic                   clk_50m,
    input  logic                   rst_n,
    input  logic [1:0]             cfg_mode,
    complex_to_mag_pipe_if.slave   s_axis,
    complex_to_mag_pipe_if.master  m_axis,
    output logic                   peak_valid,
    output logic [MAG_WIDTH-1:0]   peak_mag,
    output logic [IDX_WIDTH-1:0]   peak_idx
);

    localparam int W    = RE_IM_WIDTH;
    localparam int LW   = lin_w(W);
    localparam int SW   = sq_w(W);
    localparam int EW   = SW + MAG_WIDTH;
    localparam int DROP = drop_w(LW, MAG_WIDTH);

    logic v1, v2, v3;
    logic en1, en2, en3;
    logic s_fire;

    // A stage loads when empty or when the next stage loads this cycle.
    assign en3           = !v3 || m_axis.tready;
    assign en2           = !v2 || en3;
    assign en1           = !v1 || en2;
    assign s_axis.tready = en1;
    assign s_fire        = s_axis.tvalid && en1;

    // Mode is captured on the first beat of each frame.
    logic  fstart;
    mode_e fmode;
    mode_e in_mode;

    assign in_mode = fstart ? mode_e'(cfg_mode) : fmode;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            fstart <= 1'b1;
            fmode  <= MODE_L1;
        end else if (s_fire) begin
            fstart <= s_axis.tlast;
            if (fstart) fmode <= mode_e'(cfg_mode);
        end
    end

    // S1: absolute values; -2^(W-1) maps to 2^(W-1) as W-bit unsigned.
    logic [W-1:0] re_in, im_in, re_abs, im_abs;
    logic [W-1:0] a1, b1;
    logic         l1;
    mode_e        m1;

    assign re_in  = s_axis.tdata[2*W-1:W];
    assign im_in  = s_axis.tdata[W-1:0];
    assign re_abs = re_in[W-1] ? ~re_in + 1'b1 : re_in;
    assign im_abs = im_in[W-1] ? ~im_in + 1'b1 : im_in;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            l1 <= 1'b0;
            m1 <= MODE_L1;
        end else if (en1) begin
            v1 <= s_axis.tvalid;
            a1 <= re_abs;
            b1 <= im_abs;
            l1 <= s_axis.tlast;
            m1 <= in_mode;
        end
    end

    // S2: estimator, carried at full square width.
    logic [W-1:0]  mx, mn;
    logic [SW-1:0] est, e2;
    logic          l2;
    mode_e         m2;

    assign mx = (a1 >= b1) ? a1 : b1;
    assign mn = (a1 >= b1) ? b1 : a1;

    always_comb begin
        est = '0;
        unique case (m1)
            MODE_L1:   est = SW'(a1) + SW'(b1);
            MODE_AMBM: est = SW'(mx) + SW'(mn >> 1);
            MODE_LINF: est = SW'(mx);
            MODE_SQ:   est = SW'(a1) * SW'(a1) + SW'(b1) * SW'(b1);
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            e2 <= '0;
            l2 <= 1'b0;
            m2 <= MODE_L1;
        end else if (en2) begin
            v2 <= v1;
            e2 <= est;
            l2 <= l1;
            m2 <= m1;
        end
    end

    // S3: scale linear results to the top bits, saturate the square.
    logic [EW-1:0]        sq_sh;
    logic [LW-1:0]        lin;
    logic                 sat;
    logic [MAG_WIDTH-1:0] mag_nx, d3;
    logic                 l3;

    assign sq_sh = EW'(e2) >> SQ_SHIFT;
    assign sat   = sq_sh > EW'({MAG_WIDTH{1'b1}});
    assign lin   = e2[LW-1:0];

    always_comb begin
        mag_nx = MAG_WIDTH'(lin >> DROP);
        if (m2 == MODE_SQ) mag_nx = sat ? '1 : sq_sh[MAG_WIDTH-1:0];
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            v3 <= 1'b0;
            d3 <= '0;
            l3 <= 1'b0;
        end else if (en3) begin
            v3 <= v2;
            d3 <= mag_nx;
            l3 <= l2;
        end
    end

    assign m_axis.tvalid = v3;
    assign m_axis.tdata  = d3;
    assign m_axis.tlast  = l3;

    c2m_peak_tracker #(
        .MAG_WIDTH (MAG_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_peak (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .fire       (v3 && m_axis.tready),
        .last       (l3),
        .mag        (d3),
        .peak_valid (peak_valid),
        .peak_mag   (peak_mag),
        .peak_idx   (peak_idx)
    );

endmodule

// File: tb/tb_complex_to_mag_pipe.sv
// tb_complex_to_mag_pipe: three parameterisations driven in lockstep,
// checked against an arithmetic magnitude and peak model.
module tb_complex_to_mag_pipe;
    import complex_to_mag_pkg::*;

    localparam int LIMIT = 20000;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic        s_valid;
    logic        s_last;
    logic [47:0] s_data;
    logic        m_ready;

    logic        pv_a, pv_b, pv_c;
    logic [23:0] pm_a, pm_c;
    logic [24:0] pm_b;
    logic [9:0]  pi_a, pi_b, pi_c;

    complex_to_mag_pipe_if #(.DW(48)) sa ();
    complex_to_mag_pipe_if #(.DW(48)) sb ();
    complex_to_mag_pipe_if #(.DW(48)) sc ();
    complex_to_mag_pipe_if #(.DW(24)) ma ();
    complex_to_mag_pipe_if #(.DW(25)) mb ();
    complex_to_mag_pipe_if #(.DW(24)) mc ();

    always #10 clk_50m = ~clk_50m;

    assign sa.tvalid = s_valid;
    assign sb.tvalid = s_valid;
    assign sc.tvalid = s_valid;
    assign sa.tdata  = s_data;
    assign sb.tdata  = s_data;
    assign sc.tdata  = s_data;
    assign sa.tlast  = s_last;
    assign sb.tlast  = s_last;
    assign sc.tlast  = s_last;
    assign ma.tready = m_ready;
    assign mb.tready = m_ready;
    assign mc.tready = m_ready;

    complex_to_mag_pipe dut_a (
        .clk_50m(clk_50m), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .s_axis(sa), .m_axis(ma),
        .peak_valid(pv_a), .peak_mag(pm_a), .peak_idx(pi_a)
    );

    complex_to_mag_pipe #(.MAG_WIDTH(25)) dut_b (
        .clk_50m(clk_50m), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .s_axis(sb), .m_axis(mb),
        .peak_valid(pv_b), .peak_mag(pm_b), .peak_idx(pi_b)
    );

    complex_to_mag_pipe #(.SQ_SHIFT(0)) dut_c (
        .clk_50m(clk_50m), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .s_axis(sc), .m_axis(mc),
        .peak_valid(pv_c), .peak_mag(pm_c), .peak_idx(pi_c)
    );

    logic        o_valid[3];
    logic        o_last[3];
    logic [63:0] o_data[3];
    logic        p_valid[3];
    logic [63:0] p_mag[3];
    logic [63:0] p_idx[3];

    assign o_valid[0] = ma.tvalid;
    assign o_valid[1] = mb.tvalid;
    assign o_valid[2] = mc.tvalid;
    assign o_last[0]  = ma.tlast;
    assign o_last[1]  = mb.tlast;
    assign o_last[2]  = mc.tlast;
    assign o_data[0]  = 64'(ma.tdata);
    assign o_data[1]  = 64'(mb.tdata);
    assign o_data[2]  = 64'(mc.tdata);
    assign p_valid[0] = pv_a;
    assign p_valid[1] = pv_b;
    assign p_valid[2] = pv_c;
    assign p_mag[0]   = 64'(pm_a);
    assign p_mag[1]   = 64'(pm_b);
    assign p_mag[2]   = 64'(pm_c);
    assign p_idx[0]   = 64'(pi_a);
    assign p_idx[1]   = 64'(pi_b);
    assign p_idx[2]   = 64'(pi_c);

    int n_pass = 0;
    int n_chk  = 0;
    int mws[3];
    int sqs[3];

    int     q_re[$];
    int     q_im[$];
    bit     q_last[$];
    int     q_mode[$];
    longint got_d[3][$];
    bit     got_l[3][$];
    longint got_pm[3][$];
    int     got_pi[3][$];
    int     got_pc[3][$];
    int     in_cyc_first;
    int     out_cyc_first;
    int     last_oc;
    int     stall_err;
    bit     timeout;

    function automatic longint ref_mag(input int re, input int im,
                                       input int mode, input int mw,
                                       input int sq);
        longint ar, ai, mx, mn, r;
        ar = (re < 0) ? -longint'(re) : longint'(re);
        ai = (im < 0) ? -longint'(im) : longint'(im);
        mx = (ar > ai) ? ar : ai;
        mn = (ar > ai) ? ai : ar;
        case (mode)
            0:       r = ar + ai;
            1:       r = mx + mn / 2;
            2:       r = mx;
            default: r = ar * ar + ai * ai;
        endcase
        if (mode == 3) begin
            r = r >> sq;
            if (r > (longint'(1) << mw) - 1) r = (longint'(1) << mw) - 1;
        end else if (mw < 25) begin
            r = r >> (25 - mw);
        end
        return r;
    endfunction

    function automatic int rnd_val();
        logic [23:0] t;
        int sel;
        sel = $urandom_range(7);
        if (sel == 0) return -(1 << 23);
        if (sel == 1) return (1 << 23) - 1;
        t = 24'($urandom);
        return int'($signed(t));
    endfunction

    function automatic void q_clear();
        q_re.delete();
        q_im.delete();
        q_last.delete();
        q_mode.delete();
    endfunction

    function automatic void q_push(input int re, input int im,
                                   input bit last, input int mode);
        q_re.push_back(re);
        q_im.push_back(im);
        q_last.push_back(last);
        q_mode.push_back(mode);
    endfunction

    // Drives the queued beats and records every output and peak event.
    task automatic run_beats(input int rdy_pct, input int vld_pct);
        int     n, k, cyc, tail, r, m;
        bit     acc;
        bit     stalled[3];
        longint held[3];
        bit     heldl[3];
        n = q_re.size();
        k = 0; cyc = 0; tail = 0; acc = 0;
        stall_err = 0; timeout = 0;
        in_cyc_first = -1; out_cyc_first = -1; last_oc = -1;
        for (int i = 0; i < 3; i++) begin
            got_d[i].delete(); got_l[i].delete();
            got_pm[i].delete(); got_pi[i].delete(); got_pc[i].delete();
            stalled[i] = 0; held[i] = 0; heldl[i] = 0;
        end
        while (cyc < LIMIT && tail < 4) begin
            @(posedge clk_50m);
            #1;
            m_ready = ($urandom_range(99) < rdy_pct);
            if (!s_valid || acc) begin
                if (k < n && $urandom_range(99) < vld_pct) begin
                    r        = q_re[k];
                    m        = q_im[k];
                    s_data   = {r[23:0], m[23:0]};
                    s_last   = q_last[k];
                    cfg_mode = 2'(q_mode[k]);
                    s_valid  = 1'b1;
                end else begin
                    s_valid = 1'b0;
                end
            end
            @(negedge clk_50m);
            acc = s_valid && sa.tready;
            if (acc) begin
                if (k == 0) in_cyc_first = cyc;
                k++;
            end
            for (int i = 0; i < 3; i++) begin
                if (stalled[i] && (!o_valid[i] || o_data[i] != held[i] ||
                                   o_last[i] != heldl[i]))
                    stall_err++;
                if (o_valid[i] && m_ready) begin
                    got_d[i].push_back(o_data[i]);
                    got_l[i].push_back(o_last[i]);
                    if (i == 0 && out_cyc_first < 0) out_cyc_first = cyc;
                    if (i == 0 && o_last[i]) last_oc = cyc;
                end
                stalled[i] = o_valid[i] && !m_ready;
                held[i]    = o_data[i];
                heldl[i]   = o_last[i];
                if (p_valid[i]) begin
                    got_pm[i].push_back(p_mag[i]);
                    got_pi[i].push_back(int'(p_idx[i]));
                    got_pc[i].push_back(cyc);
                end
            end
            if (k >= n && got_d[0].size() >= n) tail++;
            cyc++;
        end
        if (cyc >= LIMIT) timeout = 1;
    endtask

    task automatic test_reset();
        s_valid = 0; s_last = 0; s_data = '0; m_ready = 0; cfg_mode = 0;
        rst_n = 0;
        repeat (3) @(posedge clk_50m);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({o_valid[i], o_last[i], p_valid[i]} !== 3'b000)
                $display("FAIL reset_flags[%0d]: got %b want 000", i,
                         {o_valid[i], o_last[i], p_valid[i]});
            else n_pass++;
            n_chk++;
            if ((o_data[i] | p_mag[i] | p_idx[i]) !== 64'd0)
                $display("FAIL reset_data[%0d]: got %0h %0h %0h want 0", i,
                         o_data[i], p_mag[i], p_idx[i]);
            else n_pass++;
        end
        n_chk++;
        if ({sa.tready, sb.tready, sc.tready} !== 3'b111)
            $display("FAIL reset_tready: got %b want 111",
                     {sa.tready, sb.tready, sc.tready});
        else n_pass++;
        @(negedge clk_50m);
        rst_n = 1;
        @(posedge clk_50m);
        #1;
        n_chk++;
        if ({o_valid[0], o_valid[1], o_valid[2]} !== 3'b000)
            $display("FAIL post_reset_valid: got %b want 000",
                     {o_valid[0], o_valid[1], o_valid[2]});
        else n_pass++;
    endtask

    task automatic test_latency_l1();
        q_clear();
        q_push(3, -4, 1, int'(MODE_L1));
        run_beats(100, 100);
        n_chk++;
        if (timeout || got_d[1].size() != 1)
            $display("FAIL lat_count: got %0d want 1", got_d[1].size());
        else n_pass++;
        n_chk++;
        if (out_cyc_first - in_cyc_first != 3)
            $display("FAIL lat_cycles: got %0d want 3",
                     out_cyc_first - in_cyc_first);
        else n_pass++;
        if (got_d[1].size() == 1) begin
            n_chk++;
            if (got_d[1][0] != 7 || got_l[1][0] != 1)
                $display("FAIL l1_3m4: got %0d last %0d want 7 last 1",
                         got_d[1][0], got_l[1][0]);
            else n_pass++;
        end
        q_clear();
        q_push(-(1 << 23), 0, 1, int'(MODE_L1));
        run_beats(100, 100);
        if (got_d[1].size() == 1 && got_d[0].size() == 1) begin
            n_chk++;
            if (got_d[1][0] != 64'd8388608)
                $display("FAIL l1_minneg_w25: got %0d want 8388608",
                         got_d[1][0]);
            else n_pass++;
            n_chk++;
            if (got_d[0][0] != 64'd4194304)
                $display("FAIL l1_minneg_w24: got %0d want 4194304",
                         got_d[0][0]);
            else n_pass++;
        end else begin
            n_chk++;
            $display("FAIL l1_minneg_count: got %0d want 1", got_d[1].size());
        end
    endtask

    task automatic test_modes();
        q_clear();
        q_push(3, -4, 1, int'(MODE_AMBM));
        q_push(3, -4, 1, int'(MODE_LINF));
        q_push(3, -4, 1, int'(MODE_SQ));
        q_push(-(1 << 23), -(1 << 23), 1, int'(MODE_SQ));
        run_beats(100, 100);
        n_chk++;
        if (got_d[1].size() != 4 || got_d[2].size() != 4 || got_d[0].size() != 4)
            $display("FAIL modes_count: got %0d want 4", got_d[1].size());
        else begin
            n_pass++;
            n_chk++;
            if (got_d[1][0] != 5) $display("FAIL ambm: got %0d want 5", got_d[1][0]);
            else n_pass++;
            n_chk++;
            if (got_d[1][1] != 4) $display("FAIL linf: got %0d want 4", got_d[1][1]);
            else n_pass++;
            n_chk++;
            if (got_d[2][2] != 25) $display("FAIL sq: got %0d want 25", got_d[2][2]);
            else n_pass++;
            n_chk++;
            if (got_d[2][3] != 64'hFFFFFF)
                $display("FAIL sq_sat: got %0h want ffffff", got_d[2][3]);
            else n_pass++;
            n_chk++;
            if (got_d[0][3] != 64'd8388608)
                $display("FAIL sq_shift24: got %0d want 8388608", got_d[0][3]);
            else n_pass++;
        end
    endtask

    task automatic test_peak();
        int mags[8] = '{1, 9, 4, 9, 2, 0, 3, 5};
        q_clear();
        for (int j = 0; j < 8; j++) q_push(mags[j], 0, j == 7, int'(MODE_LINF));
        run_beats(100, 100);
        n_chk++;
        if (got_pm[1].size() != 1 || got_pm[0].size() != 1)
            $display("FAIL peak_pulses: got %0d want 1", got_pm[1].size());
        else begin
            n_pass++;
            n_chk++;
            if (got_pm[1][0] != 9 || got_pi[1][0] != 1)
                $display("FAIL peak_w25: got mag %0d idx %0d want 9 1",
                         got_pm[1][0], got_pi[1][0]);
            else n_pass++;
            n_chk++;
            if (got_pm[0][0] != 4 || got_pi[0][0] != 1)
                $display("FAIL peak_w24: got mag %0d idx %0d want 4 1",
                         got_pm[0][0], got_pi[0][0]);
            else n_pass++;
            n_chk++;
            if (got_pc[1][0] != last_oc + 1)
                $display("FAIL peak_timing: got %0d want %0d",
                         got_pc[1][0], last_oc + 1);
            else n_pass++;
        end
    endtask

    task automatic test_mode_latch();
        int want[5] = '{7, 7, 7, 7, 4};
        q_clear();
        q_push(3, -4, 0, int'(MODE_L1));
        q_push(3, -4, 0, int'(MODE_L1));
        q_push(3, -4, 0, int'(MODE_LINF));
        q_push(3, -4, 1, int'(MODE_LINF));
        q_push(3, -4, 1, int'(MODE_LINF));
        run_beats(60, 100);
        n_chk++;
        if (got_d[1].size() != 5)
            $display("FAIL latch_count: got %0d want 5", got_d[1].size());
        else begin
            n_pass++;
            for (int j = 0; j < 5; j++) begin
                n_chk++;
                if (got_d[1][j] != longint'(want[j]))
                    $display("FAIL latch_beat%0d: got %0d want %0d", j,
                             got_d[1][j], want[j]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        m_ready = 0;
        @(posedge clk_50m); #1;
        s_data = {24'd3, 24'hFFFFFC}; s_last = 0; cfg_mode = 2'(MODE_SQ);
        s_valid = 1;
        @(posedge clk_50m); #1;
        s_data = {24'd5, 24'd12};
        @(posedge clk_50m); #1;
        s_valid = 0;
        @(posedge clk_50m); #1;
        n_chk++;
        if (o_valid[1] !== 1'b1)
            $display("FAIL midrst_inflight: got %b want 1", o_valid[1]);
        else n_pass++;
        rst_n = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (o_valid[i] !== 1'b0 || o_data[i] !== 64'd0 || o_last[i] !== 1'b0)
                $display("FAIL midrst_out[%0d]: got v%b d%0h want v0 d0",
                         i, o_valid[i], o_data[i]);
            else n_pass++;
        end
        @(negedge clk_50m);
        rst_n = 1;
        q_clear();
        q_push(5, 0, 0, int'(MODE_LINF));
        q_push(2, 0, 0, int'(MODE_LINF));
        q_push(8, 0, 1, int'(MODE_LINF));
        run_beats(100, 100);
        n_chk++;
        if (got_d[1].size() != 3 || got_pm[1].size() != 1)
            $display("FAIL midrst_count: got %0d want 3", got_d[1].size());
        else begin
            n_pass++;
            n_chk++;
            if (got_d[1][0] != 5 || got_d[1][1] != 2 || got_d[1][2] != 8)
                $display("FAIL midrst_data: got %0d %0d %0d want 5 2 8",
                         got_d[1][0], got_d[1][1], got_d[1][2]);
            else n_pass++;
            n_chk++;
            if (got_pi[1][0] != 2 || got_pm[1][0] != 8)
                $display("FAIL midrst_peak: got idx %0d mag %0d want 2 8",
                         got_pi[1][0], got_pm[1][0]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int     n, rem, fs, fm, bin, np, pidx;
        longint e, pk;
        n = 1000; rem = 0;
        q_clear();
        for (int j = 0; j < n; j++) begin
            if (rem == 0) rem = $urandom_range(1, 16);
            rem--;
            q_push(rnd_val(), rnd_val(), (rem == 0) || (j == n - 1),
                   int'($urandom_range(3)));
        end
        run_beats(50, 80);
        n_chk++;
        if (timeout || stall_err != 0)
            $display("FAIL rand_flow: timeout %0d stall_err %0d want 0 0",
                     timeout, stall_err);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (got_d[i].size() != n)
                $display("FAIL rand_count[%0d]: got %0d want %0d", i,
                         got_d[i].size(), n);
            else n_pass++;
            fs = 1; fm = 0; bin = 0; np = 0; pk = 0; pidx = 0;
            for (int j = 0; j < n; j++) begin
                if (fs) fm = q_mode[j];
                fs = q_last[j];
                e  = ref_mag(q_re[j], q_im[j], fm, mws[i], sqs[i]);
                if (j < got_d[i].size()) begin
                    n_chk++;
                    if (got_d[i][j] != e || got_l[i][j] != q_last[j])
                        $display("FAIL rand_beat[%0d] %0d: got %0d/%0d want %0d/%0d",
                                 i, j, got_d[i][j], got_l[i][j], e, q_last[j]);
                    else n_pass++;
                end
                if (bin == 0 || e > pk) begin
                    pk = e; pidx = bin;
                end
                if (q_last[j]) begin
                    if (np < got_pm[i].size()) begin
                        n_chk++;
                        if (got_pm[i][np] != pk || got_pi[i][np] != pidx)
                            $display("FAIL rand_peak[%0d] %0d: got %0d@%0d want %0d@%0d",
                                     i, np, got_pm[i][np], got_pi[i][np], pk, pidx);
                        else n_pass++;
                    end
                    np++; bin = 0;
                end else begin
                    bin++;
                end
            end
            n_chk++;
            if (got_pm[i].size() != np)
                $display("FAIL rand_peak_count[%0d]: got %0d want %0d", i,
                         got_pm[i].size(), np);
            else n_pass++;
        end
    endtask

    initial begin
        mws[0] = 24; mws[1] = 25; mws[2] = 24;
        sqs[0] = 24; sqs[1] = 24; sqs[2] = 0;
        test_reset();
        test_latency_l1();
        test_modes();
        test_peak();
        test_mode_latch();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/complex_to_mag_pipe.md
Name: complex_to_mag_pipe

Overview:
- Parametrised, fully pipelined successor to the FFT magnitude stage. Converts a stream of {Re,Im} FFT bins into magnitude estimates with a per-frame selectable estimator.
- Sits between the FFT core and the spectrum/display path.
- Adds per-frame peak-bin tracking, so downstream logic gets the strongest bin without a second pass.

Parameters:
- RE_IM_WIDTH, 24, signed width of each of Re and Im.
- MAG_WIDTH, 24, unsigned output magnitude width.
- IDX_WIDTH, 10, bin index counter width (frame length up to 2^IDX_WIDTH).
- SQ_SHIFT, 24, right shift applied to the squared-magnitude result in mode 3.

Ports:
- clk_50m  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_mode  in  2  estimator select: 0=|Re|+|Im|, 1=max+min/2, 2=max(|Re|,|Im|), 3=(Re²+Im²)>>SQ_SHIFT.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  2*RE_IM_WIDTH  {Re[MSBs], Im[LSBs]}, two's complement.
- s_axis_tlast  in  1  last bin of frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  MAG_WIDTH  magnitude.
- m_axis_tlast  out  1  last bin of frame, aligned with its data.
- peak_valid  out  1  one-cycle pulse: frame peak result available.
- peak_mag  out  MAG_WIDTH  largest magnitude of the last completed frame.
- peak_idx  out  IDX_WIDTH  bin index of that peak.

Behaviour:
- Reset (async assert on rst_n low, synchronous release): all stage valids 0, m_axis_tvalid/tlast 0, m_axis_tdata 0, peak_valid 0, peak_mag 0, peak_idx 0, bin counter 0, running peak 0, frame-start flag 1.
- Reset mid-frame discards all in-flight beats. The next accepted beat is treated as bin 0 of a new frame.
- Pipeline: 3 register stages. Latency from input handshake to m_axis_tvalid is 3 cycles when unstalled. Throughput is 1 beat/cycle with m_axis_tready held high.
  - S1: absolute values, each RE_IM_WIDTH-bit unsigned. abs(-2^(W-1)) = 2^(W-1) must be exact, with no overflow.
  - S2: estimator.
  - S3: scale/saturate into the output register.
- Stall rule: stage k loads when it is empty or stage k+1 loads in the same cycle. s_axis_tready = S1 empty or S1 advancing. No bubble is inserted when downstream frees and upstream fills in the same cycle. Data, tlast and the frame's mode travel together.
- Mode latching: cfg_mode is sampled on the first accepted beat of each frame (frame-start flag set) and held for that frame. Changes mid-frame have no effect until after the tlast beat is accepted.
- Width rules:
  - Modes 0–2 produce an RE_IM_WIDTH+1 bit result (mode 1: max + (min>>1), floor).
  - If MAG_WIDTH < RE_IM_WIDTH+1, output the top MAG_WIDTH bits; otherwise zero-extend.
  - Mode 3: exact 2*RE_IM_WIDTH-bit sum of squares, shifted right by SQ_SHIFT, saturated to all-ones if it exceeds MAG_WIDTH bits.
- Output hold: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
- Peak tracking, on each output handshake:
  - The bin counter supplies the index.
  - Update the running peak when the magnitude is strictly greater, or on bin 0, which always loads.
  - Ties keep the earlier bin.
  - On the tlast handshake: peak_mag/peak_idx take the final result (including the current beat) on the next edge, and peak_valid pulses for exactly one cycle.
  - Counter and running peak then reset for the next frame.
  - The bin counter wraps modulo 2^IDX_WIDTH with no error flag.
- Frames without tlast never produce peak_valid.

Decomposition:
- Package complex_to_mag_pkg: mode encodings (MODE_L1=0, MODE_AMBM=1, MODE_LINF=2, MODE_SQ=3) and the width-derivation helper constants.
- One sub-module: c2m_peak_tracker (bin counter, compare, peak_valid pulse), driven by the output handshake.
- The estimator pipeline stays in the top level.

Test Plan:
- Mode 0, Re=3, Im=-4, m_axis_tready=1 → m_axis_tdata=7, exactly 3 cycles after the input handshake. With MAG_WIDTH=RE_IM_WIDTH+1 override, Re=-2^23, Im=0 → 2^23. At defaults → 2^22.
- Modes 1/2/3 (SQ_SHIFT=0 instance), same Re=3, Im=-4 in three single-beat frames → outputs 5, 4, 25. Mode 3 with Re=Im=-2^23, SQ_SHIFT=0 → saturates to 0xFFFFFF.
- 8-beat frame of magnitudes 1,9,4,9,2,0,3,5 (mode 2), tlast on beat 8 → peak_valid pulses once after the last handshake, peak_mag=9, peak_idx=1.
- Random m_axis_tready throttling (~50%) over 1000 beats → output stream equals the reference model in order, tlast aligned, no drops or duplicates. Data is stable while stalled.
- Toggle cfg_mode 0→2 on beat 3 of a 4-beat frame → the whole frame uses mode 0. The next frame uses mode 2.
- Assert rst_n low for one cycle with 2 beats in flight → all outputs return to reset values immediately. The following frame's peak_idx counts from 0.
